// File: rtl/rom_burst_arb_pkg.sv
// Shared types and defaults for the ROM burst arbiter slice.
package rom_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_e;

    localparam int unsigned ADDR_W_DEF = 3;
    localparam int unsigned DATA_W_DEF = 4;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/rom_burst_arb_if.sv
// Request, ROM and response signals of rom_burst_arb grouped in one bundle.
interface rom_burst_arb_if #(
    parameter int unsigned ADDR_W = rom_arb_pkg::ADDR_W_DEF,
    parameter int unsigned DATA_W = rom_arb_pkg::DATA_W_DEF
);

    logic              req0;
    logic              req1;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;
    logic [ADDR_W-1:0] len0;
    logic [ADDR_W-1:0] len1;
    logic              gnt0;
    logic              gnt1;
    logic              rom_en;
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_data;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_id;
    logic              rsp_last;
    logic              busy;

    modport slave (
        input  req0, req1, addr0, addr1, len0, len1, rom_data,
        output gnt0, gnt1, rom_en, rom_addr, rsp_valid, rsp_data, rsp_id, rsp_last, busy
    );

    modport master (
        output req0, req1, addr0, addr1, len0, len1, rom_data,
        input  gnt0, gnt1, rom_en, rom_addr, rsp_valid, rsp_data, rsp_id, rsp_last, busy
    );

endinterface

// File: rtl/rom_burst_arb_rr_arb2.sv
// Two-input arbiter. ROM_ARB_RR_EN selects round-robin ties; otherwise requester 0
// always wins and no pointer register exists.
module rr_arb2
    import rom_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en_i,
    input  logic [1:0] req_i,
    input  logic       upd_i,
    input  logic       upd_id_i,
    output logic [1:0] gnt_o
);

`ifdef ROM_ARB_RR_EN
    // ptr_q holds the id that wins when both requesters are asking
    logic ptr_q;
    logic ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (upd_i) begin
            ptr_d = ~upd_id_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= REQ0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    always_comb begin
        gnt_o = '0;
        if (en_i) begin
            if (req_i == 2'b11) begin
                gnt_o = (ptr_q == REQ1) ? 2'b10 : 2'b01;
            end else begin
                gnt_o = req_i;
            end
        end
    end
`else
    logic unused_ok;
    assign unused_ok = ^{clk, rst_n, upd_i, upd_id_i};

    always_comb begin
        gnt_o = '0;
        if (en_i) begin
            gnt_o = {req_i[1] & ~req_i[0], req_i[0]};
        end
    end
`endif

endmodule

// File: rtl/rom_burst_arb.sv
// Burst-read arbiter and sequencer for a shared one-cycle-latency ROM.
// Build option: ROM_ARB_RR_EN enables round-robin tie breaking (default fixed priority).
module rom_burst_arb
    import rom_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input logic            clk,
    input logic            rst_n,
    rom_burst_arb_if.slave bus
);

    state_e            state_q;
    state_e            state_d;
    logic [ADDR_W-1:0] cur_q;
    logic [ADDR_W-1:0] cur_d;
    logic [ADDR_W-1:0] cnt_q;
    logic [ADDR_W-1:0] cnt_d;
    logic              id_q;
    logic              id_d;
    logic              rom_en_q;
    logic              rsp_valid_q;
    logic              rsp_id_q;
    logic              rsp_last_q;
    logic              busy_q;
    logic [1:0]        arb_gnt;
    logic [DATA_W-1:0] rom_word;

    rr_arb2 u_arb (
        .clk      (clk),
        .rst_n    (rst_n),
        .en_i     (state_q == IDLE),
        .req_i    ({bus.req1, bus.req0}),
        .upd_i    (state_q == DRAIN),
        .upd_id_i (id_q),
        .gnt_o    (arb_gnt)
    );

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        cnt_d   = cnt_q;
        id_d    = id_q;
        case (state_q)
            IDLE: begin
                if (|arb_gnt) begin
                    id_d    = arb_gnt[1] ? REQ1 : REQ0;
                    cur_d   = arb_gnt[1] ? bus.addr1 : bus.addr0;
                    cnt_d   = arb_gnt[1] ? bus.len1 : bus.len0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                // cur wraps naturally at the address width
                cur_d = cur_q + 1'b1;
                if (cnt_q == '0) begin
                    state_d = DRAIN;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DRAIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cur_q       <= '0;
            cnt_q       <= '0;
            id_q        <= REQ0;
            rom_en_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= REQ0;
            rsp_last_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_q       <= cur_d;
            cnt_q       <= cnt_d;
            id_q        <= id_d;
            rom_en_q    <= (state_d == ISSUE);
            rsp_valid_q <= rom_en_q;
            rsp_id_q    <= id_q;
            rsp_last_q  <= rom_en_q && (cnt_q == '0);
            busy_q      <= (state_d != IDLE);
        end
    end

    assign rom_word      = bus.rom_data;
    assign bus.gnt0      = arb_gnt[0];
    assign bus.gnt1      = arb_gnt[1];
    assign bus.rom_en    = rom_en_q;
    assign bus.rom_addr  = cur_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rom_word;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_last  = rsp_last_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_rom_burst_arb.sv
// Self-checking bench for rom_burst_arb: directed scenarios plus random traffic
// checked against a burst-timeline reference model.
module tb_rom_burst_arb;

`ifdef ROM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rom_burst_arb_if #(.ADDR_W(3), .DATA_W(4)) bus ();

    rom_burst_arb #(.ADDR_W(3), .DATA_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [3:0] rom_mem [8];

    // synchronous ROM, one-cycle read latency
    always @(posedge clk) begin
        if (bus.rom_en === 1'b1) bus.rom_data <= rom_mem[bus.rom_addr];
    end

    int unsigned compared = 0;
    int unsigned mismatched = 0;

    // reference model: each grant books its issue/response/busy slots on a timeline
    int unsigned s = 0;
    int unsigned free_at = 0;
    logic        ptr = 1'b0;
    logic        m_g0 = 1'b0;
    logic        m_g1 = 1'b0;
    logic        hold = 1'b0;
    logic        r_en   [16];
    logic [2:0]  r_addr [16];
    logic        r_v    [16];
    logic [3:0]  r_d    [16];
    logic        r_id   [16];
    logic        r_last [16];
    logic        r_busy [16];
    logic [13:0] e_vec;

    task automatic model_reset();
        for (int unsigned i = 0; i < 16; i++) begin
            r_en[i] = 1'b0; r_addr[i] = '0; r_v[i] = 1'b0; r_d[i] = '0;
            r_id[i] = 1'b0; r_last[i] = 1'b0; r_busy[i] = 1'b0;
        end
        free_at = s;
        ptr = 1'b0;
        m_g0 = 1'b0;
        m_g1 = 1'b0;
    endtask

    task automatic model_step();
        int unsigned j;
        logic k;
        logic [2:0] a;
        logic [2:0] l;
        j = s % 16;
        m_g0 = 1'b0;
        m_g1 = 1'b0;
        if (s >= free_at && (bus.req0 || bus.req1)) begin
            if (bus.req0 && bus.req1) k = RR ? ptr : 1'b0;
            else k = bus.req1;
            a = k ? bus.addr1 : bus.addr0;
            l = k ? bus.len1 : bus.len0;
            m_g0 = !k;
            m_g1 = k;
            for (int unsigned i = 0; i <= 32'(l); i++) begin
                r_en[(s + 1 + i) % 16]   = 1'b1;
                r_addr[(s + 1 + i) % 16] = a + 3'(i);
                r_v[(s + 2 + i) % 16]    = 1'b1;
                r_d[(s + 2 + i) % 16]    = rom_mem[a + 3'(i)];
                r_id[(s + 2 + i) % 16]   = k;
                r_last[(s + 2 + i) % 16] = (i == 32'(l));
            end
            for (int unsigned i = 1; i <= 32'(l) + 2; i++) r_busy[(s + i) % 16] = 1'b1;
            free_at = s + 3 + 32'(l);
            ptr = ~k;
        end
        e_vec = {m_g0, m_g1, r_en[j], r_en[j] ? r_addr[j] : 3'd0, r_v[j], r_last[j],
                 r_v[j] ? r_d[j] : 4'd0, r_v[j] ? r_id[j] : 1'b0, r_busy[j]};
        r_en[j] = 1'b0; r_v[j] = 1'b0; r_last[j] = 1'b0; r_busy[j] = 1'b0;
        s++;
    endtask

    function automatic logic [13:0] obs();
        return {bus.gnt0, bus.gnt1, bus.rom_en, bus.rom_en ? bus.rom_addr : 3'd0,
                bus.rsp_valid, bus.rsp_last, bus.rsp_valid ? bus.rsp_data : 4'd0,
                bus.rsp_valid ? bus.rsp_id : 1'b0, bus.busy};
    endfunction

    function automatic logic [9:0] rst_vec();
        return {bus.gnt0, bus.gnt1, bus.rom_en, bus.rom_addr, bus.rsp_valid,
                bus.rsp_id, bus.rsp_last, bus.busy};
    endfunction

    // next sample point; a granted requester lets go of req after the grant edge
    task automatic advance();
        @(negedge clk);
        if (!hold) begin
            if (m_g0) bus.req0 = 1'b0;
            if (m_g1) bus.req1 = 1'b0;
        end
    endtask

    task automatic do_reset();
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        bus.addr0 = '0; bus.addr1 = '0; bus.len0 = '0; bus.len1 = '0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        compared++;
        if (rst_vec() !== 10'b0) begin
            mismatched++;
            $display("FAIL reset_values got=%b want=%b", rst_vec(), 10'b0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        s = 0;
        model_reset();
    endtask

    task automatic test_single();
        int n = 0;
        logic [3:0] d = '0;
        logic lst = 1'b0;
        logic id = 1'b1;
        for (int c = 0; c < 6; c++) begin
            if (c == 0) begin bus.addr0 = 3'd2; bus.len0 = 3'd0; bus.req0 = 1'b1; end
            #1; model_step(); compared++;
            if (obs() !== e_vec) begin
                mismatched++;
                $display("FAIL single c=%0d got=%b want=%b", c, obs(), e_vec);
            end
            if (bus.rsp_valid === 1'b1) begin n++; d = bus.rsp_data; lst = bus.rsp_last; id = bus.rsp_id; end
            if (c == 5) begin
                compared++;
                if (bus.busy !== 1'b0) begin mismatched++; $display("FAIL single_idle busy=%b want=0", bus.busy); end
            end
            advance();
        end
        compared++;
        if (n != 1 || d !== 4'hA || lst !== 1'b1 || id !== 1'b0) begin
            mismatched++;
            $display("FAIL single_word n=%0d data=%h last=%b id=%b want 1/a/1/0", n, d, lst, id);
        end
    endtask

    task automatic test_wrap();
        logic [11:0] addrs = '0;
        logic [15:0] datas = '0;
        logic [3:0] lasts = '0;
        int na = 0;
        int nr = 0;
        for (int c = 0; c < 9; c++) begin
            if (c == 0) begin bus.addr1 = 3'd6; bus.len1 = 3'd3; bus.req1 = 1'b1; end
            #1; model_step(); compared++;
            if (obs() !== e_vec) begin
                mismatched++;
                $display("FAIL wrap c=%0d got=%b want=%b", c, obs(), e_vec);
            end
            if (bus.rom_en === 1'b1) begin addrs = {addrs[8:0], bus.rom_addr}; na++; end
            if (bus.rsp_valid === 1'b1) begin
                datas = {datas[11:0], bus.rsp_data}; lasts = {lasts[2:0], bus.rsp_last}; nr++;
            end
            advance();
        end
        compared++;
        if (na != 4 || addrs !== 12'b110_111_000_001) begin
            mismatched++; $display("FAIL wrap_addr n=%0d got=%b want=110111000001", na, addrs);
        end
        compared++;
        if (nr != 4 || datas !== 16'h9B13) begin
            mismatched++; $display("FAIL wrap_data n=%0d got=%h want=9b13", nr, datas);
        end
        compared++;
        if (lasts !== 4'b0001) begin
            mismatched++; $display("FAIL wrap_last got=%b want=0001", lasts);
        end
    endtask

    task automatic test_tie();
        logic [3:0] seq = '0;
        logic [3:0] exp_seq;
        int ng = 0;
        do_reset();
        hold = 1'b1;
        for (int c = 0; c < 16; c++) begin
            if (c == 0) begin
                bus.addr0 = 3'($urandom); bus.addr1 = 3'($urandom);
                bus.len0 = 3'd0; bus.len1 = 3'd0;
                bus.req0 = 1'b1; bus.req1 = 1'b1;
            end
            if (c == 12) begin bus.req0 = 1'b0; bus.req1 = 1'b0; end
            #1; model_step(); compared++;
            if (obs() !== e_vec) begin
                mismatched++;
                $display("FAIL tie c=%0d got=%b want=%b", c, obs(), e_vec);
            end
            if (bus.gnt0 === 1'b1 || bus.gnt1 === 1'b1) begin seq = {seq[2:0], bus.gnt1}; ng++; end
            advance();
        end
        hold = 1'b0;
        exp_seq = RR ? 4'b0101 : 4'b0000;
        compared++;
        if (ng != 4 || seq !== exp_seq) begin
            mismatched++; $display("FAIL tie_order n=%0d got=%b want=%b", ng, seq, exp_seq);
        end
    endtask

    task automatic test_late();
        int g0 = -1;
        int g1 = -1;
        for (int c = 0; c < 22; c++) begin
            if (c == 0) begin bus.addr0 = 3'($urandom); bus.len0 = 3'd7; bus.req0 = 1'b1; end
            if (c == 3) begin bus.addr1 = 3'($urandom); bus.len1 = 3'($urandom); bus.req1 = 1'b1; end
            #1; model_step(); compared++;
            if (obs() !== e_vec) begin
                mismatched++;
                $display("FAIL late c=%0d got=%b want=%b", c, obs(), e_vec);
            end
            if (bus.gnt0 === 1'b1 && g0 < 0) g0 = c;
            if (bus.gnt1 === 1'b1 && g1 < 0) g1 = c;
            advance();
        end
        compared++;
        if (g0 != 0 || g1 != g0 + 10) begin
            mismatched++; $display("FAIL late_gap gnt0_at=%0d gnt1_at=%0d want gap 10", g0, g1);
        end
    endtask

    task automatic test_abort();
        int spurious = 0;
        for (int c = 0; c < 15; c++) begin
            if (c == 0) begin bus.addr0 = 3'd0; bus.len0 = 3'd7; bus.req0 = 1'b1; end
            if (c == 6) rst_n = 1'b1;
            if (c == 9) begin bus.addr1 = 3'd1; bus.len1 = 3'd1; bus.req1 = 1'b1; end
            #1; model_step(); compared++;
            if (obs() !== e_vec) begin
                mismatched++;
                $display("FAIL abort c=%0d got=%b want=%b", c, obs(), e_vec);
            end
            if (c >= 4 && c <= 8 && (bus.rsp_valid !== 1'b0 || bus.rsp_last !== 1'b0)) spurious++;
            if (c == 9) begin
                compared++;
                if (bus.gnt1 !== 1'b1) begin mismatched++; $display("FAIL abort_idle gnt1=%b want=1", bus.gnt1); end
            end
            if (c == 3) begin
                rst_n = 1'b0;
                #1;
                compared++;
                if (rst_vec() !== 10'b0) begin
                    mismatched++; $display("FAIL abort_reset_values got=%b want=%b", rst_vec(), 10'b0);
                end
                model_reset();
            end
            advance();
        end
        compared++;
        if (spurious != 0) begin
            mismatched++; $display("FAIL abort_no_rsp spurious=%0d want=0", spurious);
        end
    endtask

    task automatic test_full();
        int busy_cnt = 0;
        int nlast = 0;
        logic [31:0] datas = '0;
        for (int c = 0; c < 14; c++) begin
            if (c == 0) begin bus.addr0 = 3'd0; bus.len0 = 3'd7; bus.req0 = 1'b1; end
            #1; model_step(); compared++;
            if (obs() !== e_vec) begin
                mismatched++;
                $display("FAIL full c=%0d got=%b want=%b", c, obs(), e_vec);
            end
            if (bus.busy === 1'b1) busy_cnt++;
            if (bus.rsp_valid === 1'b1) datas = {datas[27:0], bus.rsp_data};
            if (bus.rsp_last === 1'b1) nlast++;
            advance();
        end
        compared++;
        if (busy_cnt != 9) begin mismatched++; $display("FAIL full_busy got=%0d want=9", busy_cnt); end
        compared++;
        if (datas !== 32'h13A67D9B) begin mismatched++; $display("FAIL full_data got=%h want=13a67d9b", datas); end
        compared++;
        if (nlast != 1) begin mismatched++; $display("FAIL full_last got=%0d want=1", nlast); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 300; c++) begin
            if (c < 280) begin
                if (!bus.req0 && $urandom_range(3) == 0) begin
                    bus.addr0 = 3'($urandom); bus.len0 = 3'($urandom); bus.req0 = 1'b1;
                end
                if (!bus.req1 && $urandom_range(3) == 0) begin
                    bus.addr1 = 3'($urandom); bus.len1 = 3'($urandom); bus.req1 = 1'b1;
                end
            end
            #1; model_step(); compared++;
            if (obs() !== e_vec) begin
                mismatched++;
                $display("FAIL random c=%0d got=%b want=%b", c, obs(), e_vec);
            end
            advance();
        end
    endtask

    initial begin
        rom_mem[0] = 4'h1; rom_mem[1] = 4'h3; rom_mem[2] = 4'hA; rom_mem[3] = 4'h6;
        rom_mem[4] = 4'h7; rom_mem[5] = 4'hD; rom_mem[6] = 4'h9; rom_mem[7] = 4'hB;
        test_reset();
        test_single();
        test_wrap();
        test_tie();
        test_late();
        test_abort();
        test_full();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
